sv8000_cart_loader: RTL and testbench



---
 rtl/sv8000_cart_loader_if.sv | 23 ++
 rtl/sv8000_cart_loader.sv | 161 ++++++++++++++++
 tb/tb_sv8000_cart_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sv8000_cart_loader_if.sv
// ioctl download port and dpram port as seen by the cartridge loader.
// The loader is the master; the hps_io/dpram side is the slave.
interface sv8000_cart_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_q,
    output mem_a, mem_we, mem_d
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_q,
    input  mem_a, mem_we, mem_d
  );
endinterface

// File: rtl/sv8000_cart_loader.sv
// Cartridge loader: captures a .BIN download into the cart window, pads it to a
// power of two with 0xFF and mirrors it through the rest of the window.
module sv8000_cart_loader #(
  parameter int CART_INDEX  = 1,
  parameter int WINDOW_BITS = 15,
  parameter int MIN_BITS    = 11
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sv8000_cart_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          rom_mask,
  output logic                 overflow
);
  localparam int CW = WINDOW_BITS + 1;
  localparam logic [CW-1:0] WIN   = {1'b1, {WINDOW_BITS{1'b0}}};
  localparam logic [24:0]   WIN_A = 25'(WIN);

  typedef enum logic [2:0] {IDLE, LOAD, SIZE, PAD, MIRROR, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [CW-1:0]          size_q;
  logic [CW-1:0]          dst;
  logic                   phase_w;
  logic                   dl_q;
  logic [WINDOW_BITS-1:0] a_q;
  logic [7:0]             d_q;
  logic                   we_q;
  logic                   mirror_w;
  // Power-up value only: a console reset must not forget the loaded cart size.
  logic [15:0]            mask_q = '0;

  logic          start;
  logic          wr_ok;
  logic [CW-1:0] wr_end;
  logic [CW-1:0] size_c;

  assign start  = bus.ioctl_download && (bus.ioctl_index == 8'(CART_INDEX));
  assign wr_ok  = bus.ioctl_wr && (bus.ioctl_addr < WIN_A);
  assign wr_end = CW'(bus.ioctl_addr[WINDOW_BITS-1:0]) + CW'(1);

  always_comb begin
    size_c = WIN;
    for (int k = WINDOW_BITS; k >= MIN_BITS; k--)
      if (count <= (CW'(1) << k)) size_c = CW'(1) << k;
  end

  assign bus.mem_a  = 16'(a_q);
  assign bus.mem_we = we_q;
  // Mirror write data comes straight from the RAM read issued the cycle before.
  assign bus.mem_d  = mirror_w ? bus.mem_q : d_q;
  assign rom_mask   = mask_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      size_q   <= '0;
      dst      <= '0;
      phase_w  <= 1'b0;
      dl_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      we_q     <= 1'b0;
      mirror_w <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q     <= bus.ioctl_download;
      we_q     <= 1'b0;
      mirror_w <= 1'b0;
      done     <= 1'b0;
      // hps_io strobes data only after download is up, so the entry cycle carries no write.
      if (start && (state == IDLE || ((state == PAD || state == MIRROR) && !dl_q))) begin
        state    <= LOAD;
        busy     <= 1'b1;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (bus.ioctl_wr) begin
              if (wr_ok) begin
                we_q <= 1'b1;
                a_q  <= bus.ioctl_addr[WINDOW_BITS-1:0];
                d_q  <= bus.ioctl_dout;
                if (wr_end > count) count <= wr_end;
              end else begin
                overflow <= 1'b1;
              end
            end
            if (!bus.ioctl_download) state <= SIZE;
          end
          SIZE: begin
            size_q <= size_c;
            mask_q <= 16'(size_c - CW'(1));
            if (count == '0) begin
              mask_q <= '0;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (count < size_c) begin
              state <= PAD;
              dst   <= count;
            end else if (size_c < WIN) begin
              state   <= MIRROR;
              dst     <= size_c;
              phase_w <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          PAD: begin
            we_q <= 1'b1;
            a_q  <= dst[WINDOW_BITS-1:0];
            d_q  <= 8'hFF;
            if (dst == size_q - CW'(1)) begin
              if (size_q == WIN) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= MIRROR;
                dst     <= size_q;
                phase_w <= 1'b0;
              end
            end else begin
              dst <= dst + CW'(1);
            end
          end
          MIRROR: begin
            if (!phase_w) begin
              a_q     <= dst[WINDOW_BITS-1:0] & mask_q[WINDOW_BITS-1:0];
              phase_w <= 1'b1;
            end else begin
              a_q      <= dst[WINDOW_BITS-1:0];
              we_q     <= 1'b1;
              mirror_w <= 1'b1;
              phase_w  <= 1'b0;
              if (dst == WIN - CW'(1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                dst <= dst + CW'(1);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sv8000_cart_loader.sv
// Directed bench for sv8000_cart_loader with a 4 KiB window and 512 B mirror unit,
// which keeps every pad/mirror pass short while exercising the same boundaries.
`timescale 1ns/1ps
module tb_sv8000_cart_loader;
  localparam int WB = 12;
  localparam int MB = 9;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        busy, done, overflow;
  logic [15:0] rom_mask;

  sv8000_cart_loader_if bus();

  sv8000_cart_loader #(.CART_INDEX(1), .WINDOW_BITS(WB), .MIN_BITS(MB)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .busy(busy), .done(done), .rom_mask(rom_mask), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // dpram model: registered read, write on mem_we
  logic [7:0] ram [65536];
  logic [7:0] q;
  logic       fill = 1'b1;
  assign bus.mem_q = q;
  always @(posedge clk_sys) begin
    if (fill) for (int i = 0; i < 65536; i++) ram[i] <= 8'hAA;
    else if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
    q <= ram[bus.mem_a];
  end

  int we_cnt = 0, we_hi = 0, busy_cnt = 0, done_cnt = 0;
  always @(negedge clk_sys) begin
    if (bus.mem_we) begin
      we_cnt++;
      if (bus.mem_a[15:WB] != '0) we_hi++;
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int n, input int idx);
    bus.ioctl_index    = 8'(idx);
    bus.ioctl_download = 1'b1;
    for (int a = 0; a < n; a++) begin
      @(negedge clk_sys);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = a[7:0];
    end
    @(negedge clk_sys);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int k = 1; k <= budget && lat == 0; k++) begin
      @(negedge clk_sys);
      if (done) lat = k;
    end
  endtask

  task automatic wait_write(input int addr, output int found);
    found = 0;
    for (int k = 0; k < 5000 && found == 0; k++) begin
      @(negedge clk_sys);
      if (bus.mem_we && int'(bus.mem_a) == addr) found = 1;
    end
  endtask

  task automatic refill();
    fill = 1'b1;
    @(negedge clk_sys);
    fill = 1'b0;
  endtask

  typedef struct packed {
    int n; int idx; int mask; int ovf; int lat; int we; int bsy;
    int pa0; int pd0; int pa1; int pd1; int pa2; int pd2;
  } vec_t;

  initial begin
    vec_t v[5];
    int lat, found, we0, hi0, b0, d0;
    //        n     idx mask    ovf lat   we    bsy  probes (addr, data) x3
    v[0] = '{512,   1, 'h1FF,  0, 7170, 4096, 1, 'h200, 'h00, 'h205, 'h05, 'hFFF, 'hFF};
    v[1] = '{750,   1, 'h3FF,  0, 6420, 4096, 1, 'h2EE, 'hFF, 'h405, 'h05, 'hFFF, 'hFF};
    v[2] = '{4096,  1, 'hFFF,  0, 2,    4096, 1, 'h234, 'h34, 'h800, 'h00, 'hFFF, 'hFF};
    v[3] = '{5120,  1, 'hFFF,  1, 2,    4096, 1, 'h010, 'h10, 'h000, 'h00, 'hFFF, 'hFF};
    v[4] = '{512,   0, 'hFFF,  1, 0,    0,    0, 'h000, 'hAA, 'h100, 'hAA, 'hFFF, 'hAA};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    check("rst mem_a", int'(bus.mem_a), 0);
    check("rst mem_we", int'(bus.mem_we), 0);
    check("rst mem_d", int'(bus.mem_d), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst rom_mask", int'(rom_mask), 0);
    check("rst overflow", int'(overflow), 0);
    reset = 1'b0;
    fill  = 1'b0;
    @(negedge clk_sys);

    for (int i = 0; i < 5; i++) begin
      refill();
      we0 = we_cnt; hi0 = we_hi; b0 = busy_cnt;
      load(v[i].n, v[i].idx);
      wait_done((v[i].lat == 0) ? 64 : 20000, lat);
      repeat (4) @(negedge clk_sys);
      check($sformatf("v%0d done latency", i), lat, v[i].lat);
      check($sformatf("v%0d rom_mask", i), int'(rom_mask), v[i].mask);
      check($sformatf("v%0d overflow", i), int'(overflow), v[i].ovf);
      check($sformatf("v%0d write count", i), we_cnt - we0, v[i].we);
      check($sformatf("v%0d writes above window", i), we_hi - hi0, 0);
      check($sformatf("v%0d busy seen", i), int'(busy_cnt > b0), v[i].bsy);
      check($sformatf("v%0d ram[%0h]", i, v[i].pa0), int'(ram[v[i].pa0]), v[i].pd0);
      check($sformatf("v%0d ram[%0h]", i, v[i].pa1), int'(ram[v[i].pa1]), v[i].pd1);
      check($sformatf("v%0d ram[%0h]", i, v[i].pa2), int'(ram[v[i].pa2]), v[i].pd2);
    end

    // single write: one-cycle write latency and pad from a non-zero count
    refill();
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h5;
    bus.ioctl_dout = 8'h5A;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    check("wr mem_we", int'(bus.mem_we), 1);
    check("wr mem_a", int'(bus.mem_a), 'h5);
    check("wr mem_d", int'(bus.mem_d), 'h5A);
    @(negedge clk_sys);
    check("wr mem_we width", int'(bus.mem_we), 0);
    bus.ioctl_download = 1'b0;
    wait_done(20000, lat);
    repeat (4) @(negedge clk_sys);
    check("wr done latency", lat, 7676);
    check("wr rom_mask", int'(rom_mask), 'h1FF);
    check("wr ram[005]", int'(ram['h005]), 'h5A);
    check("wr ram[006]", int'(ram['h006]), 'hFF);
    check("wr ram[205]", int'(ram['h205]), 'h5A);

    // reset in the middle of MIRROR
    refill();
    d0 = done_cnt;
    load(512, 1);
    wait_write('h400, found);
    check("rst-mirror reached", found, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst-mirror busy", int'(busy), 0);
    check("rst-mirror mem_we", int'(bus.mem_we), 0);
    check("rst-mirror done", int'(done), 0);
    check("rst-mirror rom_mask held", int'(rom_mask), 'h1FF);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("rst-mirror no done", done_cnt - d0, 0);
    refill();
    load(512, 1);
    wait_done(20000, lat);
    repeat (4) @(negedge clk_sys);
    check("rst-reload latency", lat, 7170);
    check("rst-reload rom_mask", int'(rom_mask), 'h1FF);
    check("rst-reload ram[FFF]", int'(ram['hFFF]), 'hFF);

    // new download during MIRROR aborts straight into LOAD
    refill();
    d0 = done_cnt;
    load(512, 1);
    wait_write('h400, found);
    check("abort mirror reached", found, 1);
    load(4096, 1);
    wait_done(20000, lat);
    repeat (4) @(negedge clk_sys);
    check("abort done latency", lat, 2);
    check("abort done pulses", done_cnt - d0, 1);
    check("abort rom_mask", int'(rom_mask), 'hFFF);
    check("abort ram[400]", int'(ram['h400]), 'h00);
    check("abort ram[801]", int'(ram['h801]), 'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
